// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    ARB_CORE      = 1'b0,
    ARB_HOST_LOCK = 1'b1
  } arb_state_t;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_HOST = 1'b1
  } req_id_t;

  localparam int DMEM_AW_DEF = 8;
  localparam int DMEM_DW_DEF = 8;

endpackage : dmem_arb_pkg

// File: rtl/arb_rsp_reg.sv
// Per-requester read response register: captures memory data on a granted
// read and raises rvalid for exactly the following cycle.
module arb_rsp_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cap_en,
  input  logic [DW-1:0] cap_data,
  output logic          rvalid,
  output logic [DW-1:0] rdata
);

  logic          rvalid_d, rvalid_q;
  logic [DW-1:0] rdata_d,  rdata_q;

  // Next-state: pulse on capture, data holds until the next capture.
  always_comb begin
    rvalid_d = cap_en;
    rdata_d  = rdata_q;
    if (cap_en) begin
      rdata_d = cap_data;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Response registers; reset drops any pending pulse and clears data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule : arb_rsp_reg

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single dat_mem port. The core has
// priority; a saturating starvation counter and a host lock mode make sure
// the host always gets through.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW      = DMEM_AW_DEF,
  parameter int DW      = DMEM_DW_DEF,
  parameter int MAXWAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_stall,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic          host_lock,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          mem_wr_en,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dat_in,
  input  logic [DW-1:0] mem_dat_out
);

  localparam int            WW        = $clog2(MAXWAIT + 1);
  localparam logic [WW-1:0] MAXWAIT_C = WW'(MAXWAIT);

  arb_state_t    state_d, state_q;
  logic [WW-1:0] wait_cnt_d, wait_cnt_q;
  logic          starve;
  logic          core_gnt_c, host_gnt_c;
  req_id_t       sel;

  // Grant decision from the arbitration state and the starvation counter.
  always_comb begin
    starve     = (wait_cnt_q == MAXWAIT_C);
    core_gnt_c = 1'b0;
    host_gnt_c = 1'b0;
    case (state_q)
      ARB_CORE: begin
        host_gnt_c = host_req & (~core_req | starve);
        core_gnt_c = core_req & ~host_gnt_c;
      end
      ARB_HOST_LOCK: begin
        host_gnt_c = host_req;
        core_gnt_c = 1'b0;
      end
      default: begin
        host_gnt_c = 1'b0;
        core_gnt_c = 1'b0;
      end
    endcase
  end

  // Grants are gated by reset so nothing reaches memory while it is held.
  assign host_gnt   = host_gnt_c & ~reset;
  assign core_gnt   = core_gnt_c & ~reset;
  assign core_stall = core_req & ~core_gnt;

  // Memory port mux: drive from the granted requester, idle to zero.
  always_comb begin
    sel        = host_gnt ? REQ_HOST : REQ_CORE;
    mem_wr_en  = 1'b0;
    mem_rd_en  = 1'b0;
    mem_addr   = '0;
    mem_dat_in = '0;
    if (host_gnt | core_gnt) begin
      case (sel)
        REQ_HOST: begin
          mem_wr_en  = host_we;
          mem_rd_en  = ~host_we;
          mem_addr   = host_addr;
          mem_dat_in = host_wdata;
        end
        REQ_CORE: begin
          mem_wr_en  = core_we;
          mem_rd_en  = ~core_we;
          mem_addr   = core_addr;
          mem_dat_in = core_wdata;
        end
        default: begin
          mem_wr_en  = 1'b0;
          mem_rd_en  = 1'b0;
          mem_addr   = '0;
          mem_dat_in = '0;
        end
      endcase
    end else begin
      mem_wr_en = 1'b0;
      mem_rd_en = 1'b0;
    end
  end

  // Next state for the lock FSM and the host starvation counter.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    if (host_req & ~host_gnt) begin
      if (starve) begin
        wait_cnt_d = wait_cnt_q;
      end else begin
        wait_cnt_d = wait_cnt_q + WW'(1);
      end
    end else begin
      wait_cnt_d = '0;
    end
    case (state_q)
      ARB_CORE: begin
        if (host_gnt & host_lock) begin
          state_d = ARB_HOST_LOCK;
        end else begin
          state_d = ARB_CORE;
        end
      end
      ARB_HOST_LOCK: begin
        if (~host_lock) begin
          state_d = ARB_CORE;
        end else begin
          state_d = ARB_HOST_LOCK;
        end
      end
      default: begin
        state_d = ARB_CORE;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB_CORE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  arb_rsp_reg #(.DW(DW)) u_core_rsp (
    .clk      (clk),
    .reset    (reset),
    .cap_en   (core_gnt & ~core_we),
    .cap_data (mem_dat_out),
    .rvalid   (core_rvalid),
    .rdata    (core_rdata)
  );

  arb_rsp_reg #(.DW(DW)) u_host_rsp (
    .clk      (clk),
    .reset    (reset),
    .cap_en   (host_gnt & ~host_we),
    .cap_data (mem_dat_out),
    .rvalid   (host_rvalid),
    .rdata    (host_rdata)
  );

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small dat_mem model.
module tb_dmem_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk;
  logic          reset;
  logic          core_req, core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_gnt, core_stall, core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          host_req, host_we, host_lock;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          mem_wr_en, mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dat_in, mem_dat_out;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks;
  int errors;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAXWAIT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_gnt    (core_gnt),
    .core_stall  (core_stall),
    .core_rvalid (core_rvalid),
    .core_rdata  (core_rdata),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_lock   (host_lock),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .mem_wr_en   (mem_wr_en),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_dat_in  (mem_dat_in),
    .mem_dat_out (mem_dat_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dat_mem model: synchronous write, combinational read.
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_dat_in;
  end
  assign mem_dat_out = mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_lock = 1'b0; host_addr = '0; host_wdata = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    idle_inputs();
    reset = 1'b1;

    // Reset state, with a core request present to prove gating.
    tick();
    core_req = 1'b1; core_addr = 8'h10;
    #1;
    check("rst_core_gnt", core_gnt, 1'b0);
    check("rst_core_stall", core_stall, 1'b1);
    check("rst_mem_rd_en", mem_rd_en, 1'b0);
    check("rst_core_rvalid", core_rvalid, 1'b0);
    check("rst_core_rdata", core_rdata, 8'h00);
    check("rst_host_rdata", host_rdata, 8'h00);
    core_req = 1'b0; core_addr = '0;
    tick();
    reset = 1'b0;
    tick();

    // Idle outputs.
    check("idle_gnts", {core_gnt, host_gnt, core_stall}, 3'b000);
    check("idle_mem", {mem_wr_en, mem_rd_en, mem_addr, mem_dat_in}, 18'h0);
    check("idle_rvalid", {core_rvalid, host_rvalid}, 2'b00);

    // Core read of 0x10 (0xA5), zero-latency grant, one-cycle response.
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h10;
    #1;
    check("crd_gnt", core_gnt, 1'b1);
    check("crd_stall", core_stall, 1'b0);
    check("crd_mem", {mem_rd_en, mem_wr_en, mem_addr}, {1'b1, 1'b0, 8'h10});
    tick();
    core_req = 1'b0; core_addr = '0;
    check("crd_rvalid", core_rvalid, 1'b1);
    check("crd_rdata", core_rdata, 8'hA5);
    tick();
    check("crd_rvalid_end", core_rvalid, 1'b0);
    check("crd_rdata_hold", core_rdata, 8'hA5);

    // Core write 0x3C to 0x20, then host read of 0x20 next cycle.
    core_req = 1'b1; core_we = 1'b1; core_addr = 8'h20; core_wdata = 8'h3C;
    #1;
    check("cwr_gnt", core_gnt, 1'b1);
    check("cwr_mem", {mem_wr_en, mem_rd_en, mem_addr, mem_dat_in}, {1'b1, 1'b0, 8'h20, 8'h3C});
    tick();
    idle_inputs();
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
    #1;
    check("hrd_gnt", host_gnt, 1'b1);
    check("cwr_no_rvalid", core_rvalid, 1'b0);
    tick();
    idle_inputs();
    check("hrd_rvalid", host_rvalid, 1'b1);
    check("hrd_rdata", host_rdata, 8'h3C);
    tick();
    check("hrd_rvalid_end", host_rvalid, 1'b0);

    // Starvation: both request continuously, host wins every 5th cycle.
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h10;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("stv_host_gnt_%0d", i), host_gnt, (i % 5 == 4) ? 1'b1 : 1'b0);
      check($sformatf("stv_core_stall_%0d", i), core_stall, (i % 5 == 4) ? 1'b1 : 1'b0);
      check($sformatf("stv_host_rvalid_%0d", i), host_rvalid, (i == 5) ? 1'b1 : 1'b0);
      tick();
    end
    idle_inputs();
    check("stv_host_rvalid_last", host_rvalid, 1'b1);
    check("stv_host_rdata", host_rdata, 8'h3C);
    tick();

    // Lock burst: acquire lock while the core is idle, then 8 writes with
    // the core requesting; lock drops together with the last write.
    host_req = 1'b1; host_we = 1'b1; host_lock = 1'b1; host_addr = 8'h00; host_wdata = 8'h50;
    #1;
    check("lck_acquire", host_gnt, 1'b1);
    tick();
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h10;
    for (int i = 0; i < 8; i++) begin
      host_addr = 8'(i); host_wdata = 8'(8'h50 + i);
      host_lock = (i != 7);
      #1;
      check($sformatf("lck_host_gnt_%0d", i), host_gnt, 1'b1);
      check($sformatf("lck_core_stall_%0d", i), core_stall, 1'b1);
      tick();
    end
    host_req = 1'b0; host_we = 1'b0; host_lock = 1'b0;
    #1;
    check("lck_core_after", core_gnt, 1'b1);
    tick();
    check("lck_core_rdata", core_rdata, 8'hA5);
    core_req = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h05;
    #1;
    check("lck_rb_gnt", host_gnt, 1'b1);
    tick();
    idle_inputs();
    check("lck_rb_data", host_rdata, 8'h55);

    // Idle lock holds the memory: host_req low, core still blocked.
    host_req = 1'b1; host_we = 1'b1; host_lock = 1'b1; host_addr = 8'h31; host_wdata = 8'h11;
    tick();
    host_req = 1'b0; core_req = 1'b1; core_addr = 8'h10;
    #1;
    check("lidle_core_gnt", core_gnt, 1'b0);
    tick();
    check("lidle_core_gnt2", core_gnt, 1'b0);

    // Reset clears the lock: core vs host afterwards, core wins.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_lock = 1'b0; host_addr = 8'h20;
    #1;
    check("rlck_core_gnt", core_gnt, 1'b1);
    check("rlck_host_gnt", host_gnt, 1'b0);
    tick();
    idle_inputs();
    tick();

    // Async reset during a granted core read; host write during reset.
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h10;
    #1;
    check("arst_pre_gnt", core_gnt, 1'b1);
    #1;
    reset = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h30; host_wdata = 8'h77;
    #1;
    check("arst_gnts", {core_gnt, host_gnt}, 2'b00);
    check("arst_wr_en", mem_wr_en, 1'b0);
    tick();
    check("arst_no_rvalid", core_rvalid, 1'b0);
    check("arst_rdata_clr", core_rdata, 8'h00);
    idle_inputs();
    reset = 1'b0;
    tick();
    check("arst_no_rvalid2", core_rvalid, 1'b0);
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h30;
    tick();
    idle_inputs();
    check("arst_mem_kept", host_rdata, 8'h00);
    check("arst_rd_valid", host_rvalid, 1'b1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_dmem_arbiter

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single `dat_mem` port between the core load/store path and a host/loader port used for data preload and result readback. Core has priority; a starvation counter and a host lock mode guarantee host progress. It sits between the core's memory control (`MemWrite`/`MemtoReg`/ALU address) and `dat_mem`. It drives a stall to the core and returns registered read data to each requester.

## Interface
- `AW`, default 8: memory address width.
- `DW`, default 8: data width.
- `MAXWAIT`, default 4: consecutive denied host cycles before the host is forced ahead of the core. Legal range is ≥1.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `core_req`, `core_we` in 1 each: core request and write select.
- `core_addr` in AW; `core_wdata` in DW: core address and write data.
- `core_gnt` out 1: core request accepted this cycle.
- `core_stall` out 1: equals `core_req & ~core_gnt`.
- `core_rvalid` out 1; `core_rdata` out DW: core read response.
- `host_req`, `host_we`, `host_lock` in 1 each: host request, write select and burst lock.
- `host_addr` in AW; `host_wdata` in DW: host address and write data.
- `host_gnt` out 1; `host_rvalid` out 1; `host_rdata` out DW: host grant and read response.
- `mem_wr_en`, `mem_rd_en` out 1 each: to `dat_mem` `wr_en` and `rd_en`.
- `mem_addr` out AW; `mem_dat_in` out DW: to `dat_mem`.
- `mem_dat_out` in DW: combinational read data from `dat_mem`.

## Operation
- States: `ARB_CORE` (default, core priority) and `ARB_HOST_LOCK` (host owns the memory).
- Grant in `ARB_CORE`:
  - `host_gnt = host_req & (~core_req | starve)`, where `starve = (wait_cnt == MAXWAIT)`.
  - `core_gnt = core_req & ~host_gnt`.
- Grant in `ARB_HOST_LOCK`:
  - `host_gnt = host_req`.
  - `core_gnt = 0`.
- Grants are combinational, at most one per cycle, and forced to 0 while `reset` is high.
- Memory mux:
  - With a grant, `mem_addr`/`mem_dat_in` come from the granted port, `mem_wr_en = we`, `mem_rd_en = ~we`.
  - With no grant, `mem_wr_en = mem_rd_en = 0` and `mem_addr = mem_dat_in = 0`.
- `wait_cnt` (width `$clog2(MAXWAIT+1)`):
  - Increments when `host_req & ~host_gnt`, saturating at MAXWAIT.
  - Clears on `host_gnt` or when `host_req` is low.
- FSM transitions:
  - `ARB_CORE` → `ARB_HOST_LOCK` when `host_gnt & host_lock`.
  - `ARB_HOST_LOCK` → `ARB_CORE` when `host_lock` is low. While locked, `host_req` may idle without releasing the lock.
- Read response:
  - On a granted read, `mem_dat_out` is captured into that requester's `rdata` register at the clock edge.
  - Its `rvalid` is high for exactly the following cycle.
  - Writes produce no `rvalid`.
- `rdata` holds its value until the next read response for that requester.

## Timing
- Reset values: state `ARB_CORE`, `wait_cnt` 0, both `rvalid` 0, both `rdata` 0. All grants and `mem_*` enables are 0 while reset is asserted.
- Grant latency is 0 cycles (same cycle as the request). Read latency is 1 cycle from grant to `rvalid`.
- A write is committed at the edge closing its grant cycle.
- A read granted in the next cycle, from either port, returns the new data. Back-to-back alternating grants are allowed.
- Requesters hold `req`/`addr`/`we`/`wdata` stable until `gnt`. The core uses `core_stall` to freeze the PC.
- Simultaneous core and host requests with `wait_cnt < MAXWAIT`: core wins.
- Simultaneous core and host requests with `wait_cnt == MAXWAIT`: host wins, core is stalled exactly 1 cycle, and the counter clears.
- `host_lock` dropping in the same cycle as a host request: that request is still granted by the lock state, and the FSM returns to `ARB_CORE` at the next edge.
- Reset mid-operation: any pending `rvalid` is dropped and a lock is released. The write of the current cycle is suppressed because enables are gated.

## Structure
- Package `dmem_arb_pkg` holds:
  - `arb_state_t` enum {`ARB_CORE`, `ARB_HOST_LOCK`}.
  - `req_id_t` enum {`REQ_CORE`, `REQ_HOST`}.
  - Default AW/DW constants.
- Sub-module `arb_rsp_reg` (params DW): the rvalid/rdata capture register. It is instanced once per requester.
- Top-level integration: replace the direct `dat_mem` hookup with this block and gate PC advance with `core_stall`.

## Test plan
- Reset, then idle: all outputs are 0. A core read of addr 0x10, with memory holding 0xA5, gives `core_gnt` on the same cycle and `core_rvalid`/`core_rdata` = 0xA5 one cycle later.
- Core write 0x3C to 0x20, then host read of 0x20 next cycle: `host_rdata` = 0x3C and `host_rvalid` is a single 1-cycle pulse.
- With MAXWAIT=4, core and host both request continuously: host is denied 4 cycles and granted on cycle 5. `core_stall` is high exactly that cycle. The pattern repeats every 5 cycles.
- Host lock burst: host writes 0x00–0x07 with `host_lock` high while `core_req` is high throughout. Core is stalled for all 8 cycles. Core is granted the cycle after `host_lock` falls.
- Reset asserted asynchronously during a granted core read: `core_rvalid` never pulses and state returns to `ARB_CORE`. A host write issued in the reset cycle does not alter memory.
